ghost_move_scheduler: RTL and testbench
=======================================

Name: ghost_move_scheduler

Overview:
Time-multiplexes one shared ghost_control pathfinding instance across all ghosts once per game frame.
- On each frame_tick, snapshots the pacman position.
- Presents each ghost's position and previous direction to ghost_control in turn, then captures the returned move.
- Steps that ghost's pixel position, with horizontal tunnel wrap.
- Sits between the frame timing generator and the sprite renderer; owns the ghost position/direction registers.

Parameters:
NUM_GHOSTS, 4, ghost count; index 0..3 = blinky, pinky, inky, clyde
GC_LATENCY, 2, cycles from gc_* inputs stable to gc_move_dir valid (min 1)
STEP_PX, 1, pixels moved per frame per ghost
H_MIN, 343, leftmost ghost centre x (336+7)
H_MAX, 1263, rightmost ghost centre x
HOME_X, {4 x 11'd791}, packed reset x per ghost (ghost i in bits [11i+10:11i])
HOME_Y, {4 x 10'd370}, packed reset y per ghost

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle start-of-round pulse
pacman_x  in  11  pacman centre x
pacman_y  in  10  pacman centre y
gc_ghost_x  out  11  to ghost_control ghost_curr_pos_x
gc_ghost_y  out  10  to ghost_control ghost_curr_pos_y
gc_pacman_x  out  11  snapshot to ghost_control pacman_curr_pos_x
gc_pacman_y  out  10  snapshot to ghost_control pacman_curr_pos_y
gc_prev_dir  out  4  to ghost_control prev_direction
gc_move_dir  in  4  from ghost_control move_direction
ghost_pos_x  out  11*NUM_GHOSTS  packed ghost x
ghost_pos_y  out  10*NUM_GHOSTS  packed ghost y
ghost_dir  out  4*NUM_GHOSTS  packed last direction
busy  out  1  round in progress
round_done  out  1  one-cycle pulse at end of round
overrun  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-high.
- Direction encoding (one-hot): 0001 right, 0010 left, 0100 down, 1000 up, 0000 no move.
- Reset values:
  - positions = HOME_X/HOME_Y.
  - ghost_dir = 0001 for all ghosts.
  - gc_* outputs = 0.
  - busy, round_done, overrun = 0.
  - FSM in IDLE; idx = 0.
- IDLE: on frame_tick, latch pacman_x/y into gc_pacman_x/y, set idx=0 and busy=1, go to ISSUE.
- ISSUE (1 cycle): register gc_ghost_x/y and gc_prev_dir from ghost[idx]; load wait counter = GC_LATENCY; go to WAIT.
- WAIT (GC_LATENCY cycles): decrement the counter; on reaching 0, go to UPDATE.
- UPDATE (1 cycle): sample gc_move_dir and apply it:
  - Right: x += STEP_PX; if the result > H_MAX, x = H_MIN.
  - Left: if x < H_MIN+STEP_PX, x = H_MAX; else x -= STEP_PX.
  - Down: y += STEP_PX.
  - Up: y -= STEP_PX.
  - 0000 or non-one-hot: position and ghost_dir unchanged.
  - Otherwise ghost_dir[idx] = gc_move_dir.
  - Then: if idx == NUM_GHOSTS-1, go to DONE; else idx++ and go to ISSUE.
- DONE: round_done=1 for one cycle, busy=0, go to IDLE.
- Round latency: round_done is high in cycle NUM_GHOSTS*(GC_LATENCY+2)+1 after the tick edge (17 with defaults).
- Pacman snapshot is held for the whole round; pacman_x/y changes mid-round are ignored.
- frame_tick while busy (including the DONE cycle): ignored and sets overrun; only rst clears overrun.
- Vertical bounds: no wrap; wall legality is guaranteed upstream by ghost_control.
- Arithmetic: x in 12-bit and y in 11-bit intermediates, truncated after the wrap check.
- rst mid-round: immediate return to reset values; no partial update survives.

Optional Feature:
GHOST_SCHED_FREEZE_EN
- Defined: adds input freeze (1 bit). If freeze is sampled high with frame_tick, the scheduler skips ISSUE/WAIT/UPDATE:
  - goes straight to DONE (round_done the cycle after the tick);
  - positions and directions unchanged;
  - busy=1 for that one cycle.
- Undefined: no freeze port; every tick runs a full round.

Decomposition:
- Package ghost_pkg:
  - DIR_RIGHT/LEFT/DOWN/UP/NONE constants;
  - H_VISIBLE_START=336, V_VISIBLE_START=27, MOVE_TO_CENTER=7, SCALING_FACTOR=16;
  - ghost index constants;
  - FSM state enum {IDLE, ISSUE, WAIT, UPDATE, DONE}.
- Sub-module ghost_pos_stepper: combinational x/y/dir in, direction + STEP_PX + H_MIN/H_MAX, returns next x/y and a valid flag. Reused later by the pacman mover.

Test Plan:
- Reset then idle: ghost_pos_x = {4{791}}, ghost_pos_y = {4{370}}, ghost_dir = {4{0001}}, busy=0, no round_done.
- Tick with pacman (615,466); model returns 0100 for all ghosts after 2 cycles:
  - gc_pacman_x=615 for the whole round;
  - round_done at cycle 17;
  - every ghost y=371, ghost_dir=0100.
- Ghost 0 at x=1263, model returns 0001 → x=343. Ghost 1 at x=343, model returns 0010 → x=1263.
- Model returns 0000 for ghost 2 and 0110 for ghost 3 → both positions and ghost_dir unchanged.
- Overrun and snapshot:
  - second tick at cycle 5 of a round → overrun=1 and no extra round;
  - pacman_x changed mid-round → gc_pacman_x still 615.
- rst asserted during WAIT of ghost 1 → outputs at HOME values on the same edge. With GHOST_SCHED_FREEZE_EN: freeze+tick → round_done next cycle, positions unchanged.

Source files
------------

// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared ghost constants, direction encoding and scheduler states
package ghost_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b1000;

  localparam int H_VISIBLE_START = 336;
  localparam int V_VISIBLE_START = 27;
  localparam int MOVE_TO_CENTER  = 7;
  localparam int SCALING_FACTOR  = 16;

  localparam int GHOST_BLINKY = 0;
  localparam int GHOST_PINKY  = 1;
  localparam int GHOST_INKY   = 2;
  localparam int GHOST_CLYDE  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/ghost_pos_stepper.sv
// rtl/ghost_pos_stepper.sv - one-step position update with horizontal tunnel wrap
module ghost_pos_stepper
  import ghost_pkg::*;
#(
  parameter int STEP_PX = 1,
  parameter int H_MIN   = 343,
  parameter int H_MAX   = 1263
) (
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic [3:0]  dir,
  output logic [10:0] next_x,
  output logic [9:0]  next_y,
  output logic        valid
);

  logic [11:0] x_wide;

  always_comb begin
    x_wide = {1'b0, x} + 12'(STEP_PX);
    next_x = x;
    next_y = y;
    valid  = 1'b1;
    case (dir)
      DIR_RIGHT: next_x = (x_wide > 12'(H_MAX)) ? 11'(H_MIN) : x_wide[10:0];
      DIR_LEFT:  next_x = ({1'b0, x} < 12'(H_MIN + STEP_PX)) ? 11'(H_MAX) : x - 11'(STEP_PX);
      DIR_DOWN:  next_y = y + 10'(STEP_PX);
      DIR_UP:    next_y = y - 10'(STEP_PX);
      // no move and any non-one-hot code leave the ghost where it is
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ghost_move_scheduler.sv
// rtl/ghost_move_scheduler.sv - shares one ghost_control instance across all ghosts each frame
// Optional GHOST_SCHED_FREEZE_EN adds a freeze input that turns a tick into an empty round.
module ghost_move_scheduler
  import ghost_pkg::*;
#(
  parameter int NUM_GHOSTS = 4,
  parameter int GC_LATENCY = 2,
  parameter int STEP_PX    = 1,
  parameter int H_MIN      = 343,
  parameter int H_MAX      = 1263,
  parameter logic [11*NUM_GHOSTS-1:0] HOME_X = {NUM_GHOSTS{11'd791}},
  parameter logic [10*NUM_GHOSTS-1:0] HOME_Y = {NUM_GHOSTS{10'd370}}
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef GHOST_SCHED_FREEZE_EN
  input  logic                       freeze,
`endif
  input  logic                       frame_tick,
  input  logic [10:0]                pacman_x,
  input  logic [9:0]                 pacman_y,
  output logic [10:0]                gc_ghost_x,
  output logic [9:0]                 gc_ghost_y,
  output logic [10:0]                gc_pacman_x,
  output logic [9:0]                 gc_pacman_y,
  output logic [3:0]                 gc_prev_dir,
  input  logic [3:0]                 gc_move_dir,
  output logic [11*NUM_GHOSTS-1:0]   ghost_pos_x,
  output logic [10*NUM_GHOSTS-1:0]   ghost_pos_y,
  output logic [4*NUM_GHOSTS-1:0]    ghost_dir,
  output logic                       busy,
  output logic                       round_done,
  output logic                       overrun
);

  localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int CNT_W = $clog2(GC_LATENCY + 1);

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [10:0]      next_x;
  logic [9:0]       next_y;
  logic             step_valid;
  logic             skip_round;

`ifdef GHOST_SCHED_FREEZE_EN
  assign skip_round = freeze;
`else
  assign skip_round = 1'b0;
`endif

  ghost_pos_stepper #(
    .STEP_PX (STEP_PX),
    .H_MIN   (H_MIN),
    .H_MAX   (H_MAX)
  ) u_stepper (
    .x      (ghost_pos_x[11*idx +: 11]),
    .y      (ghost_pos_y[10*idx +: 10]),
    .dir    (gc_move_dir),
    .next_x (next_x),
    .next_y (next_y),
    .valid  (step_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      gc_ghost_x  <= '0;
      gc_ghost_y  <= '0;
      gc_pacman_x <= '0;
      gc_pacman_y <= '0;
      gc_prev_dir <= '0;
      ghost_pos_x <= HOME_X;
      ghost_pos_y <= HOME_Y;
      ghost_dir   <= {NUM_GHOSTS{DIR_RIGHT}};
      busy        <= 1'b0;
      round_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      round_done <= 1'b0;
      // busy covers every non-IDLE state, including DONE
      if (frame_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            gc_pacman_x <= pacman_x;
            gc_pacman_y <= pacman_y;
            idx         <= '0;
            busy        <= 1'b1;
            state       <= skip_round ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          gc_ghost_x  <= ghost_pos_x[11*idx +: 11];
          gc_ghost_y  <= ghost_pos_y[10*idx +: 10];
          gc_prev_dir <= ghost_dir[4*idx +: 4];
          wait_cnt    <= CNT_W'(GC_LATENCY);
          state       <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) state <= UPDATE;
        end
        UPDATE: begin
          if (step_valid) begin
            ghost_pos_x[11*idx +: 11] <= next_x;
            ghost_pos_y[10*idx +: 10] <= next_y;
            ghost_dir[4*idx +: 4]     <= gc_move_dir;
          end
          if (idx == IDX_W'(NUM_GHOSTS - 1)) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        DONE: begin
          round_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// tb/tb_ghost_move_scheduler.sv - directed vector bench for ghost_move_scheduler
module tb_ghost_move_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        frame_tick = 1'b0;
  logic [10:0] pacman_x = '0;
  logic [9:0]  pacman_y = '0;
  logic [10:0] gc_ghost_x, gc_pacman_x;
  logic [9:0]  gc_ghost_y, gc_pacman_y;
  logic [3:0]  gc_prev_dir;
  logic [3:0]  gc_move_dir = '0;
  logic [43:0] ghost_pos_x;
  logic [39:0] ghost_pos_y;
  logic [15:0] ghost_dir;
  logic        busy, round_done, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [43:0] cur_x;
  logic [39:0] cur_y;
  logic [15:0] cur_d;

  typedef struct {
    logic [10:0] px;
    logic [9:0]  py;
    logic [15:0] d;
    logic [43:0] ex;
    logic [39:0] ey;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs [4];

  ghost_move_scheduler dut (
    .clk         (clk),
    .rst         (rst),
`ifdef GHOST_SCHED_FREEZE_EN
    .freeze      (freeze),
`endif
    .frame_tick  (frame_tick),
    .pacman_x    (pacman_x),
    .pacman_y    (pacman_y),
    .gc_ghost_x  (gc_ghost_x),
    .gc_ghost_y  (gc_ghost_y),
    .gc_pacman_x (gc_pacman_x),
    .gc_pacman_y (gc_pacman_y),
    .gc_prev_dir (gc_prev_dir),
    .gc_move_dir (gc_move_dir),
    .ghost_pos_x (ghost_pos_x),
    .ghost_pos_y (ghost_pos_y),
    .ghost_dir   (ghost_dir),
    .busy        (busy),
    .round_done  (round_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " ghost_pos_x"}, 64'(ghost_pos_x), 64'(cur_x));
    check({tag, " ghost_pos_y"}, 64'(ghost_pos_y), 64'(cur_y));
    check({tag, " ghost_dir"},   64'(ghost_dir),   64'(cur_d));
  endtask

  // One full round; ghost g's move is valid only in the cycle before its UPDATE edge.
  task automatic run_round(input logic [10:0] px, input logic [9:0] py, input logic [15:0] d,
                           input bit chk, input bit extra_tick);
    int rd_at;
    rd_at = -1;
    @(negedge clk);
    frame_tick = 1'b1;
    pacman_x   = px;
    pacman_y   = py;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      gc_move_dir = (c % 4 == 3 && c <= 15) ? d[4*(c/4) +: 4] : 4'b0000;
      if (c == 2) begin
        pacman_x = 11'd5;
        pacman_y = 10'd9;
      end
      if (extra_tick) frame_tick = (c == 4);
      if (round_done && rd_at < 0) rd_at = c;
      if (chk) begin
        if (c % 4 == 2 && c <= 14) begin
          check("gc_ghost_x",  64'(gc_ghost_x),  64'(cur_x[11*(c/4) +: 11]));
          check("gc_ghost_y",  64'(gc_ghost_y),  64'(cur_y[10*(c/4) +: 10]));
          check("gc_prev_dir", 64'(gc_prev_dir), 64'(cur_d[4*(c/4) +: 4]));
        end
        if (c == 10) begin
          check("gc_pacman_x held", 64'(gc_pacman_x), 64'(px));
          check("gc_pacman_y held", 64'(gc_pacman_y), 64'(py));
        end
        if (c == 16) check("busy in DONE", 64'(busy), 64'd1);
        if (c == 17) check("busy after round", 64'(busy), 64'd0);
      end
    end
    check("round_done cycle", 64'(rd_at), 64'd17);
  endtask

  initial begin
    vecs[0] = '{11'd615, 10'd466, 16'h4444, {4{11'd791}}, {4{10'd371}}, 16'h4444};
    vecs[1] = '{11'd100, 10'd200, 16'h6021, {11'd791, 11'd791, 11'd1263, 11'd343},
                {4{10'd371}}, 16'h4421};
    vecs[2] = '{11'd700, 10'd300, 16'h4812, {11'd791, 11'd791, 11'd343, 11'd1263},
                {10'd372, 10'd370, 10'd371, 10'd371}, 16'h4812};
    vecs[3] = '{11'd615, 10'd466, 16'h843F, {11'd791, 11'd791, 11'd343, 11'd1263},
                {4{10'd371}}, 16'h8412};

    cur_x = {4{11'd791}};
    cur_y = {4{10'd370}};
    cur_d = 16'h1111;

    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    check("reset gc_pacman_x", 64'(gc_pacman_x), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("idle round_done", 64'(round_done), 64'd0);
    end
    check_state("idle");

    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        // walk blinky right to the right edge and pinky left to the left edge
        for (int r = 0; r < 448; r++) run_round(11'd615, 10'd466, 16'h0021, 1'b0, 1'b0);
        for (int r = 0; r < 24; r++)  run_round(11'd615, 10'd466, 16'h0001, 1'b0, 1'b0);
        cur_x = {11'd791, 11'd791, 11'd343, 11'd1263};
        cur_d = 16'h4421;
        check_state("edge walk");
      end
      run_round(vecs[i].px, vecs[i].py, vecs[i].d, 1'b1, 1'b0);
      cur_x = vecs[i].ex;
      cur_y = vecs[i].ey;
      cur_d = vecs[i].ed;
      check_state($sformatf("vec%0d", i));
    end

    check("overrun before", 64'(overrun), 64'd0);
    run_round(11'd615, 10'd466, 16'h0000, 1'b1, 1'b1);
    check("overrun set", 64'(overrun), 64'd1);
    begin
      int extra;
      extra = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (round_done || busy) extra++;
      end
      check("no extra round", 64'(extra), 64'd0);
    end
    check_state("after overrun");

    // reset while pinky is waiting on ghost_control
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      gc_move_dir = (c == 3) ? 4'b0100 : 4'b0000;
    end
    check("blinky moved pre-rst", 64'(ghost_pos_y[9:0]), 64'd372);
    rst = 1'b1;
    #1;
    cur_x = {4{11'd791}};
    cur_y = {4{10'd370}};
    cur_d = 16'h1111;
    check_state("mid-round rst");
    check("rst busy", 64'(busy), 64'd0);
    check("rst overrun", 64'(overrun), 64'd0);
    check("rst gc_ghost_x", 64'(gc_ghost_x), 64'd0);
    check("rst gc_prev_dir", 64'(gc_prev_dir), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_round(11'd400, 10'd100, 16'h0000, 1'b1, 1'b0);
    check_state("post-rst round");

`ifdef GHOST_SCHED_FREEZE_EN
    @(negedge clk);
    freeze     = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    freeze     = 1'b0;
    frame_tick = 1'b0;
    check("freeze busy", 64'(busy), 64'd1);
    check("freeze no done yet", 64'(round_done), 64'd0);
    @(posedge clk); #1;
    check("freeze round_done", 64'(round_done), 64'd1);
    check("freeze busy cleared", 64'(busy), 64'd0);
    check_state("freeze");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
